// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared definitions for the bit-serial adder/subtractor.
//   - state_e   : FSM encoding (IDLE / RUN / DONE)
//   - WIDTH_MIN / WIDTH_MAX : legal operand width range, checked at elaboration
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational one-bit full adder.
//   x, y, cin : addend bits and carry-in
//   s         : sum bit
//   cout      : carry-out (majority of the three inputs)
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor, LSB first.
//   clk, rst        : clock, asynchronous active-high reset
//   start, sub      : request (sampled when not busy) and mode (0 = A+B, 1 = A-B)
//   a, b            : WIDTH-bit operands, sampled with start
//   busy            : operation in flight
//   done            : one-cycle pulse, result fields valid
//   sum             : WIDTH-bit result, held until the next accepted start
//   carry_out       : unsigned carry (inverted borrow for subtract)
//   overflow        : signed overflow of the completed operation
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
    $error("serial_addsub: WIDTH out of legal range");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               co_q, co_d;
  logic               ov_q, ov_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic fa_s, fa_cout, last_bit, cmsb;

  fa_cell u_fa (
    .x   (sa_q[0]),
    .y   (sb_q[0]),
    .cin (c_q),
    .s   (fa_s),
    .cout(fa_cout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  // Carry into the MSB; the final bit is processed on the completion edge,
  // so this is just the live carry register during that bit.
  assign cmsb     = c_q;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ov_d    = ov_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          sa_d    = a;
          // Subtract as A + ~B + 1: invert B and preload the carry with 1.
          sb_d    = sub ? ~b : b;
          c_d     = sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d = {fa_s, res_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = fa_cout;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // res_d already holds the final bit, so it is LSB-aligned here.
          sum_d   = res_d;
          co_d    = fa_cout;
          ov_d    = cmsb ^ fa_cout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  localparam int NI = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        st[NI];
  logic        sb[NI];
  logic [31:0] av[NI];
  logic [31:0] bv[NI];
  logic        busy_w[NI];
  logic        done_w[NI];
  logic        co_w[NI];
  logic        ov_w[NI];
  logic [31:0] sum_w[NI];

  logic [3:0]  s0;
  logic [7:0]  s1;
  logic [1:0]  s2;
  logic [4:0]  s3;
  logic [31:0] s4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign sum_w[0] = {28'd0, s0};
  assign sum_w[1] = {24'd0, s1};
  assign sum_w[2] = {30'd0, s2};
  assign sum_w[3] = {27'd0, s3};
  assign sum_w[4] = s4;

  serial_addsub #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]), .a(av[0][3:0]), .b(bv[0][3:0]),
    .busy(busy_w[0]), .done(done_w[0]), .sum(s0), .carry_out(co_w[0]), .overflow(ov_w[0]));
  serial_addsub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]), .a(av[1][7:0]), .b(bv[1][7:0]),
    .busy(busy_w[1]), .done(done_w[1]), .sum(s1), .carry_out(co_w[1]), .overflow(ov_w[1]));
  serial_addsub #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]), .a(av[2][1:0]), .b(bv[2][1:0]),
    .busy(busy_w[2]), .done(done_w[2]), .sum(s2), .carry_out(co_w[2]), .overflow(ov_w[2]));
  serial_addsub #(.WIDTH(5)) u_w5 (
    .clk(clk), .rst(rst), .start(st[3]), .sub(sb[3]), .a(av[3][4:0]), .b(bv[3][4:0]),
    .busy(busy_w[3]), .done(done_w[3]), .sum(s3), .carry_out(co_w[3]), .overflow(ov_w[3]));
  serial_addsub #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .start(st[4]), .sub(sb[4]), .a(av[4]), .b(bv[4]),
    .busy(busy_w[4]), .done(done_w[4]), .sum(s4), .carry_out(co_w[4]), .overflow(ov_w[4]));

  function automatic int width_of(input int idx);
    case (idx)
      0: return 4;
      1: return 8;
      2: return 2;
      3: return 5;
      default: return 32;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference: widened add, signed overflow from operand/result signs.
  task automatic ref_op(input int w, input logic s, input logic [31:0] a_, input logic [31:0] b_,
                        output logic [31:0] rs, output logic rc, output logic ro);
    logic [32:0] full;
    logic [31:0] m, bb, aa;
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa   = a_ & m;
    bb   = (s ? ~b_ : b_) & m;
    full = {1'b0, aa} + {1'b0, bb} + {32'd0, s};
    rs   = full[31:0] & m;
    rc   = full[w];
    ro   = (aa[w-1] == bb[w-1]) && (rs[w-1] != aa[w-1]);
  endtask

  // Count edges from the current one until done is seen (sampled on negedge).
  task automatic wait_done(input int idx, input string tag, inout int lat);
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!done_w[idx]) chk({tag, "_busy_run"}, {31'd0, busy_w[idx]}, 32'd1);
    end while (!done_w[idx] && lat < 80);
    chk({tag, "_done_seen"}, {31'd0, done_w[idx]}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, busy_w[idx]}, 32'd0);
    chk({tag, "_latency"}, lat, width_of(idx));
  endtask

  // Called at a negedge; leaves the bench at the negedge of the DONE cycle.
  task automatic run_op(input int idx, input string tag, input logic s,
                        input logic [31:0] a_, input logic [31:0] b_,
                        input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    st[idx] = 1'b1; sb[idx] = s; av[idx] = a_; bv[idx] = b_;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    st[idx] = 1'b0;
    chk({tag, "_busy_k"}, {31'd0, busy_w[idx]}, 32'd1);
    wait_done(idx, tag, lat);
    chk({tag, "_sum"}, sum_w[idx], es);
    chk({tag, "_cout"}, {31'd0, co_w[idx]}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, ov_w[idx]}, {31'd0, eo});
  endtask

  task automatic chk_zero(input int idx, input string tag);
    chk({tag, "_busy"}, {31'd0, busy_w[idx]}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_w[idx]}, 32'd0);
    chk({tag, "_sum"}, sum_w[idx], 32'd0);
    chk({tag, "_cout"}, {31'd0, co_w[idx]}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ov_w[idx]}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, es;
    logic        rs_, ec, eo;
    int          lat;
    for (int i = 0; i < NI; i++) begin
      st[i] = 1'b0; sb[i] = 1'b0; av[i] = '0; bv[i] = '0;
    end
    rst = 1'b1;
    #3;
    for (int i = 0; i < NI; i++) chk_zero(i, $sformatf("reset%0d", i));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // WIDTH=4 directed
    run_op(0, "w4_add_5_3", 1'b0, 32'd5, 32'd3, 32'b1000, 1'b0, 1'b1);
    run_op(0, "w4_sub_3_5", 1'b1, 32'd3, 32'd5, 32'b1110, 1'b0, 1'b0);
    run_op(0, "w4_sub_5_3", 1'b1, 32'd5, 32'd3, 32'b0010, 1'b1, 1'b0);

    // WIDTH=8 directed
    run_op(1, "w8_ff_01", 1'b0, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0);
    run_op(1, "w8_7f_01", 1'b0, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b1);
    @(negedge clk);

    // Start re-asserted with new operands during RUN, then held into DONE.
    st[1] = 1'b1; sb[1] = 1'b0; av[1] = 32'h10; bv[1] = 32'h20;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    sb[1] = 1'b1; av[1] = 32'h40; bv[1] = 32'h05;
    wait_done(1, "restart_op1", lat);
    chk("restart_op1_sum", sum_w[1], 32'h30);
    chk("restart_op1_cout", {31'd0, co_w[1]}, 32'd0);
    chk("restart_op1_ovf", {31'd0, ov_w[1]}, 32'd0);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    st[1] = 1'b0;
    chk("restart_single_done", {31'd0, done_w[1]}, 32'd0);
    chk("restart_op2_busy", {31'd0, busy_w[1]}, 32'd1);
    wait_done(1, "restart_op2", lat);
    chk("restart_op2_sum", sum_w[1], 32'h3B);
    chk("restart_op2_cout", {31'd0, co_w[1]}, 32'd1);
    chk("restart_op2_ovf", {31'd0, ov_w[1]}, 32'd0);
    @(negedge clk);

    // Asynchronous reset during RUN; previous result (0x3B, carry 1) must clear.
    st[1] = 1'b1; sb[1] = 1'b0; av[1] = 32'h12; bv[1] = 32'h34;
    @(posedge clk);
    @(negedge clk);
    st[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero(1, "midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(1, "after_rst", 1'b0, 32'h12, 32'h34, 32'h46, 1'b0, 1'b0);

    // Random sweeps, back-to-back.
    for (int idx = 2; idx < NI; idx++) begin
      for (int n = 0; n < 1000; n++) begin
        ra  = $urandom;
        rb  = $urandom;
        rs_ = 1'($urandom_range(0, 1));
        ref_op(width_of(idx), rs_, ra, rb, es, ec, eo);
        run_op(idx, $sformatf("rnd_w%0d_%0d", width_of(idx), n), rs_, ra, rb, es, ec, eo);
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
